// File: rtl/error_injector_pkg.sv
// error_inj_pkg: shared constants for the payload error injector.
// Mode encodings, LFSR taps/seed and frame geometry used by framer and checker.
package error_inj_pkg;

    typedef enum logic [1:0] {
        MODE_PASS  = 2'd0,
        MODE_BYTE  = 2'd1,
        MODE_BIT   = 2'd2,
        MODE_BURST = 2'd3
    } mode_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } inj_st_e;

    // Galois taps for x^16+x^14+x^13+x^11+1 (right-shifting form)
    localparam logic [15:0] LFSR_TAPS     = 16'hB400;
    localparam logic [15:0] LFSR_SEED_DEF = 16'hACE1;

    // 4-row frame geometry
    localparam int FAS_COLS_DEF = 16;
    localparam int CRC_ROW_DEF  = 3;
    localparam int CRC_COL_DEF  = 1040;

endpackage

// File: rtl/error_injector_if.sv
// error_injector_if: byte-lane frame stream (position, byte, qualifier, FAS).
// master drives the stream, slave receives it.
interface error_injector_if #(
    parameter int DATA_W = 8,
    parameter int ROW_W  = 2,
    parameter int COL_W  = 11
);

    logic [ROW_W-1:0]  row_cnt;
    logic [COL_W-1:0]  col_cnt;
    logic [DATA_W-1:0] data;
    logic              valid;
    logic              fas;

    modport master (
        output row_cnt,
        output col_cnt,
        output data,
        output valid,
        output fas
    );

    modport slave (
        input row_cnt,
        input col_cnt,
        input data,
        input valid,
        input fas
    );

endinterface

// File: rtl/error_injector_lfsr16.sv
// lfsr16: 16-bit Galois LFSR advanced by i_en, reset to SEED.
// Ports: i_clk, i_rst (async, high), i_en (advance), o_lfsr (state).
module lfsr16
    import error_inj_pkg::*;
#(
    parameter logic [15:0] SEED = LFSR_SEED_DEF
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_en,
    output logic [15:0] o_lfsr
);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_lfsr <= SEED;
        end else if (i_en) begin
            o_lfsr <= {1'b0, o_lfsr[15:1]}
                    ^ (o_lfsr[0] ? LFSR_TAPS : 16'h0000);
        end
    end

endmodule

// File: rtl/error_injector.sv
// error_injector: corrupts payload bytes of the 4-row frame (byte/bit/burst).
// Ports: i_clk, i_rst; s_in (framer payload in), m_out (to serialiser);
//   i_corrupt_en, i_mode, i_rate_thresh, i_burst_len, i_cnt_clr controls;
//   o_err_cnt (saturating corrupted-byte count), o_burst_active.
module error_injector
    import error_inj_pkg::*;
#(
    parameter int          DATA_W    = 8,
    parameter int          ROW_W     = 2,
    parameter int          COL_W     = 11,
    parameter int          FAS_COLS  = FAS_COLS_DEF,
    parameter int          CRC_ROW   = CRC_ROW_DEF,
    parameter int          CRC_COL   = CRC_COL_DEF,
    parameter logic [15:0] LFSR_SEED = LFSR_SEED_DEF,
    parameter int          CNT_W     = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    error_injector_if.slave  s_in,
    error_injector_if.master m_out,
    input  logic             i_corrupt_en,
    input  logic [1:0]       i_mode,
    input  logic [7:0]       i_rate_thresh,
    input  logic [7:0]       i_burst_len,
    input  logic             i_cnt_clr,
    output logic [CNT_W-1:0] o_err_cnt,
    output logic             o_burst_active
);

    localparam int SEL_W = $clog2(DATA_W);

    logic [15:0]       lfsr;
    mode_e             mode;
    inj_st_e           state;
    logic [7:0]        left;
    logic [7:0]        blen;
    logic              prot;
    logic              elig;
    logic              trig;
    logic              burst_go;
    logic [DATA_W-1:0] byte_mask;
    logic [DATA_W-1:0] bit_mask;
    logic [DATA_W-1:0] mask;

    // Pattern source; steps once per valid byte so the
    // receiver checker can reproduce the same sequence.
    lfsr16 #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_en   (s_in.valid),
        .o_lfsr (lfsr)
    );

    assign mode = mode_e'(i_mode);
    assign blen = (i_burst_len == 8'd0) ? 8'd1 : i_burst_len;

    assign prot =
        ((s_in.row_cnt == '0)
         && (s_in.col_cnt < COL_W'(FAS_COLS)))
        || ((s_in.row_cnt == ROW_W'(CRC_ROW))
         && (s_in.col_cnt == COL_W'(CRC_COL)));

    assign elig = s_in.valid && !prot && i_corrupt_en
                  && (mode != MODE_PASS);
    assign trig = elig && (lfsr[7:0] < i_rate_thresh);

    // Burst continues only while still enabled in burst mode;
    // otherwise the byte is treated as if idle.
    assign burst_go = (state == ST_BURST) && i_corrupt_en
                      && (mode == MODE_BURST);

    assign bit_mask = DATA_W'(1) << lfsr[SEL_W+7:8];

    always_comb begin
        byte_mask = DATA_W'(lfsr[15:8]);
        // A zero mask would let a triggered byte through intact
        if (byte_mask == '0) begin
            byte_mask = DATA_W'(1);
        end
    end

    always_comb begin
        mask = '0;
        if (burst_go) begin
            if (elig) begin
                mask = byte_mask;
            end
        end else if (trig) begin
            unique case (mode)
                MODE_BIT:   mask = bit_mask;
                MODE_BYTE:  mask = byte_mask;
                MODE_BURST: mask = byte_mask;
                default:    mask = '0;
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= ST_IDLE;
            left  <= '0;
        end else if (burst_go) begin
            if (elig) begin
                left <= left - 8'd1;
                if (left == 8'd1) begin
                    state <= ST_IDLE;
                end
            end
        end else if (trig && (mode == MODE_BURST)
                     && (blen != 8'd1)) begin
            state <= ST_BURST;
            left  <= blen - 8'd1;
        end else begin
            state <= ST_IDLE;
            left  <= '0;
        end
    end

    assign o_burst_active = (state == ST_BURST);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            m_out.row_cnt <= '0;
            m_out.col_cnt <= '0;
            m_out.data    <= '0;
            m_out.valid   <= 1'b0;
            m_out.fas     <= 1'b0;
            o_err_cnt     <= '0;
        end else begin
            m_out.row_cnt <= s_in.row_cnt;
            m_out.col_cnt <= s_in.col_cnt;
            m_out.data    <= s_in.data ^ mask;
            m_out.valid   <= s_in.valid;
            m_out.fas     <= s_in.fas & s_in.valid;
            if (i_cnt_clr) begin
                o_err_cnt <= '0;
            end else if ((mask != '0) && (o_err_cnt != '1)) begin
                o_err_cnt <= o_err_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_error_injector.sv
// tb_error_injector: random and directed stimulus against a frame-level
// reference model; second instance with a 4-bit counter for saturation.
module tb_error_injector;
    import error_inj_pkg::*;

    localparam int COLS = 1041;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        en;
    logic [1:0]  mode;
    logic [7:0]  thresh;
    logic [7:0]  blen;
    logic        clr;
    logic [15:0] cnt;
    logic [3:0]  cnt4;
    logic        burst;
    logic        burst4;

    always #5 i_clk = ~i_clk;

    error_injector_if #(.DATA_W(8), .ROW_W(2), .COL_W(11)) in_if ();
    error_injector_if #(.DATA_W(8), .ROW_W(2), .COL_W(11)) out_if ();
    error_injector_if #(.DATA_W(8), .ROW_W(2), .COL_W(11)) out4_if ();

    error_injector #(.CNT_W(16)) dut (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .s_in           (in_if),
        .m_out          (out_if),
        .i_corrupt_en   (en),
        .i_mode         (mode),
        .i_rate_thresh  (thresh),
        .i_burst_len    (blen),
        .i_cnt_clr      (clr),
        .o_err_cnt      (cnt),
        .o_burst_active (burst)
    );

    error_injector #(.CNT_W(4)) dut4 (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .s_in           (in_if),
        .m_out          (out4_if),
        .i_corrupt_en   (en),
        .i_mode         (mode),
        .i_rate_thresh  (thresh),
        .i_burst_len    (blen),
        .i_cnt_clr      (clr),
        .o_err_cnt      (cnt4),
        .o_burst_active (burst4)
    );

    int n_chk  = 0;
    int n_pass = 0;

    // reference model state
    logic [15:0] m_lfsr;
    int          m_left;
    int          m_cnt;
    int          m_cnt4;
    logic        g_prot;
    logic [7:0]  g_lo;
    int          diffs;

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h t=%0t",
                      tag, got, exp, $time);
    endtask

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
    endfunction

    function automatic logic [7:0] bmask(input logic [15:0] s);
        return (s[15:8] == 8'h00) ? 8'h01 : s[15:8];
    endfunction

    task automatic model_reset();
        m_lfsr = 16'hACE1;
        m_left = 0;
        m_cnt  = 0;
        m_cnt4 = 0;
    endtask

    // Apply one cycle of input, predict, then check after the edge.
    task automatic step(input int r, input int c,
                        input logic [7:0] d,
                        input logic v, input logic f);
        logic [7:0] mk;
        logic       el;
        in_if.row_cnt = 2'(r);
        in_if.col_cnt = 11'(c);
        in_if.data    = d;
        in_if.valid   = v;
        in_if.fas     = f;
        mk     = 8'h00;
        g_prot = (r == 0 && c < 16) || (r == 3 && c == 1040);
        g_lo   = m_lfsr[7:0];
        el     = v && !g_prot && en && (mode != 2'd0);
        if (m_left > 0 && (!en || mode != 2'd3)) m_left = 0;
        if (m_left > 0) begin
            if (el) begin
                mk = bmask(m_lfsr);
                m_left--;
            end
        end else if (el && (m_lfsr[7:0] < thresh)) begin
            case (mode)
                2'd1: mk = bmask(m_lfsr);
                2'd2: mk = 8'h01 << m_lfsr[10:8];
                2'd3: begin
                    mk = bmask(m_lfsr);
                    m_left = ((blen == 0) ? 1 : int'(blen)) - 1;
                end
                default: mk = 8'h00;
            endcase
        end
        if (clr) begin
            m_cnt  = 0;
            m_cnt4 = 0;
        end else if (mk != 8'h00) begin
            if (m_cnt < 65535) m_cnt++;
            if (m_cnt4 < 15) m_cnt4++;
        end
        if (v) m_lfsr = lfsr_next(m_lfsr);
        @(posedge i_clk);
        #1;
        chk("data", 32'(out_if.data), 32'(d ^ mk));
        chk("valid", 32'(out_if.valid), 32'(v));
        chk("fas", 32'(out_if.fas), 32'(f & v));
        chk("burst", 32'(burst), 32'(m_left > 0));
        chk("burst4", 32'(burst4), 32'(m_left > 0));
        chk("cnt", 32'(cnt), 32'(m_cnt));
        chk("cnt4", 32'(cnt4), 32'(m_cnt4));
    endtask

    task automatic clear_cnt();
        clr = 1'b1;
        step(1, 0, 8'h00, 1'b0, 1'b0);
        clr = 1'b0;
    endtask

    task automatic frame(input bit zero_data, input int test);
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < COLS; c++) begin
                logic [7:0] d;
                d = zero_data ? 8'h00 : 8'($urandom);
                step(r, c, d, 1'b1, (r == 0 && c < 16));
                if (out_if.data != d) diffs++;
                if (test == 2) begin
                    if (g_prot) chk("prot", 32'(out_if.data), 32'(d));
                    else chk("byte_diff", 32'(out_if.data != d),
                             32'(g_lo != 8'hFF));
                end
                if (test == 3 && !g_prot)
                    chk("bit_one", 32'($countones(out_if.data)),
                        32'((g_lo != 8'hFF) ? 1 : 0));
            end
        end
    endtask

    task automatic pass_seg(input int n);
        for (int i = 0; i < n; i++) begin
            logic [7:0] d;
            d = 8'($urandom);
            step(1, 20 + i, d, ($urandom % 4) != 0, 1'($urandom));
            chk("pass", 32'(out_if.data), 32'(d));
        end
    endtask

    initial begin
        logic        trg;
        logic [15:0] c0;
        logic [7:0]  d;
        int          r;
        int          c;
        logic        v;
        i_rst = 1'b1;
        en = 1'b0; mode = 2'd0; thresh = 8'd0;
        blen = 8'd0; clr = 1'b0;
        in_if.row_cnt = '0; in_if.col_cnt = '0;
        in_if.data = '0; in_if.valid = 1'b0; in_if.fas = 1'b0;
        model_reset();
        diffs = 0;
        repeat (2) @(posedge i_clk);
        #1;
        chk("rst_data", 32'(out_if.data), 32'd0);
        chk("rst_valid", 32'(out_if.valid), 32'd0);
        chk("rst_cnt", 32'(cnt), 32'd0);
        chk("rst_lfsr0", 32'(dut.u_lfsr.o_lfsr), 32'hACE1);
        i_rst = 1'b0;

        // burst running when reset hits mid-frame
        en = 1'b1; mode = 2'd3; thresh = 8'd255; blen = 8'd8;
        for (int i = 0; i < 6; i++)
            step(1, 30 + i, 8'($urandom), 1'b1, 1'b1);
        #3 i_rst = 1'b1;
        #1;
        chk("arst_data", 32'(out_if.data), 32'd0);
        chk("arst_valid", 32'(out_if.valid), 32'd0);
        chk("arst_fas", 32'(out_if.fas), 32'd0);
        chk("arst_cnt", 32'(cnt), 32'd0);
        chk("arst_burst", 32'(burst), 32'd0);
        @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        model_reset();
        chk("arst_lfsr", 32'(dut.u_lfsr.o_lfsr), 32'hACE1);

        // byte mode over a full frame
        clear_cnt();
        mode = 2'd1; thresh = 8'd255; diffs = 0;
        frame(1'b0, 2);
        chk("cnt_diff", 32'(cnt), 32'(diffs));
        chk("sat4", 32'(cnt4), 32'd15);

        // bit mode, zero data
        mode = 2'd2;
        frame(1'b1, 3);

        // burst of 5 in row 1
        mode = 2'd3; blen = 8'd5; thresh = 8'd0;
        for (int k = 95; k < 100; k++) step(1, k, 8'($urandom), 1'b1, 1'b0);
        c0 = cnt; diffs = 0; trg = 1'b0;
        for (int k = 100; k < 111; k++) begin
            d = 8'($urandom);
            thresh = (k == 100) ? 8'd255 : 8'd0;
            step(1, k, d, 1'b1, 1'b0);
            if (k == 100) trg = (g_lo != 8'hFF);
            if (out_if.data != d) diffs++;
        end
        chk("burst_span", 32'(diffs), trg ? 32'd5 : 32'd0);
        chk("burst_cnt", 32'(cnt - c0), trg ? 32'd5 : 32'd0);

        // burst wrapping over the CRC byte and the next FAS columns
        c0 = cnt; diffs = 0; trg = 1'b0;
        for (int k = 1030; k < 1041; k++) begin
            d = 8'($urandom);
            thresh = (k == 1038) ? 8'd255 : 8'd0;
            step(3, k, d, 1'b1, 1'b0);
            if (k == 1038) trg = (g_lo != 8'hFF);
            if (out_if.data != d) diffs++;
            if (k == 1040) chk("crc_prot", 32'(out_if.data), 32'(d));
        end
        for (int k = 0; k < 26; k++) begin
            d = 8'($urandom);
            step(0, k, d, 1'b1, k < 16);
            if (out_if.data != d) diffs++;
            if (k < 16) chk("fas_prot", 32'(out_if.data), 32'(d));
        end
        chk("wrap_span", 32'(diffs), trg ? 32'd5 : 32'd0);
        chk("wrap_cnt", 32'(cnt - c0), trg ? 32'd5 : 32'd0);

        // abort on third burst byte
        diffs = 0; trg = 1'b0;
        for (int k = 197; k < 207; k++) begin
            d = 8'($urandom);
            thresh = (k == 200) ? 8'd255 : 8'd0;
            en = (k != 202);
            step(2, k, d, 1'b1, 1'b0);
            if (k == 200) trg = (g_lo != 8'hFF);
            if (out_if.data != d) diffs++;
            if (k == 202) begin
                chk("abort_pass", 32'(out_if.data), 32'(d));
                chk("abort_idle", 32'(burst), 32'd0);
            end
        end
        chk("abort_span", 32'(diffs), trg ? 32'd2 : 32'd0);
        en = 1'b1;

        // clear wins over a simultaneous error
        mode = 2'd1; thresh = 8'd255; clr = 1'b1;
        step(1, 50, 8'($urandom), 1'b1, 1'b0);
        clr = 1'b0;
        chk("clr_win", 32'(cnt), 32'd0);
        chk("clr_win4", 32'(cnt4), 32'd0);

        // pass-through cases
        clear_cnt();
        en = 1'b0; mode = 2'd1; thresh = 8'd255;
        pass_seg(200);
        en = 1'b1; mode = 2'd0;
        pass_seg(200);
        mode = 2'd2; thresh = 8'd0;
        pass_seg(200);
        chk("pass_cnt", 32'(cnt), 32'd0);

        // random mix
        r = 0; c = 0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom % 16 == 0) en = ($urandom % 5) != 0;
            if ($urandom % 16 == 0) mode = 2'($urandom);
            if ($urandom % 8 == 0) thresh = 8'($urandom);
            if ($urandom % 16 == 0) blen = 8'($urandom % 8);
            clr = ($urandom % 200) == 0;
            v = ($urandom % 4) != 0;
            step(r, c, 8'($urandom), v, 1'($urandom));
            if (v) begin
                c++;
                if (c == COLS) begin
                    c = 0;
                    r = (r + 1) % 4;
                end
            end
        end
        clr = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
